// File: rtl/ex_stage.sv
// ECNURVCORE execute stage: combinational ALU, iterative shift-add MUL, EX/MEM register.
// Optional macro EX_FLUSH_EN adds flush_i to squash the stage and abort a multiply.
module ex_stage #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned L_CODE_W    = 3,
  parameter int unsigned S_CODE_W    = 2,
  parameter int unsigned HOLD_CODE_W = 3,
  parameter int unsigned HOLD_EX     = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [HOLD_CODE_W-1:0] hold_code,
  input  logic [XLEN-1:0]        alu_op_num1_i,
  input  logic [XLEN-1:0]        alu_op_num2_i,
  input  logic [XLEN-1:0]        data_rs2_i,
  input  logic [4:0]             addr_rd_i,
  input  logic                   reg_wr_en_i,
  input  logic [L_CODE_W-1:0]    load_code_i,
  input  logic [S_CODE_W-1:0]    store_code_i,
  input  logic [2:0]             alu_operation_i,
  input  logic                   alu_add_sub_i,
  input  logic                   alu_shift_i,
  input  logic                   alu_mul_i,
`ifdef EX_FLUSH_EN
  input  logic                   flush_i,
`endif
  output logic [XLEN-1:0]        alu_result_o,
  output logic [XLEN-1:0]        data_rs2_o,
  output logic [4:0]             addr_rd_o,
  output logic                   reg_wr_en_o,
  output logic [L_CODE_W-1:0]    load_code_o,
  output logic [S_CODE_W-1:0]    store_code_o,
  output logic [XLEN-1:0]        data_bypass_o,
  output logic                   hold_req_o
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [XLEN-1:0]    mcand_q, mplier_q, acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [4:0]         rd_q;
  logic               wr_q;
  logic [XLEN-1:0]    alu_res;
  logic [CNT_W-1:0]   shamt;
  logic               flush;
  logic               ex_we;
  logic [XLEN-1:0]    res_d, rs2_d;
  logic [4:0]         rd_d;
  logic               wr_d;
  logic [L_CODE_W-1:0] lc_d;
  logic [S_CODE_W-1:0] sc_d;

`ifdef EX_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  assign shamt = alu_op_num2_i[CNT_W-1:0];

  // Single-cycle ALU
  always_comb begin
    alu_res = '0;
    case (alu_operation_i)
      3'b000: alu_res = alu_add_sub_i ? alu_op_num1_i - alu_op_num2_i
                                      : alu_op_num1_i + alu_op_num2_i;
      3'b001: alu_res = alu_op_num1_i << shamt;
      3'b010: alu_res = {{(XLEN-1){1'b0}}, $signed(alu_op_num1_i) < $signed(alu_op_num2_i)};
      3'b011: alu_res = {{(XLEN-1){1'b0}}, alu_op_num1_i < alu_op_num2_i};
      3'b100: alu_res = alu_op_num1_i ^ alu_op_num2_i;
      3'b101: alu_res = alu_shift_i ? $unsigned($signed(alu_op_num1_i) >>> shamt)
                                    : alu_op_num1_i >> shamt;
      3'b110: alu_res = alu_op_num1_i | alu_op_num2_i;
      default: alu_res = alu_op_num1_i & alu_op_num2_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, stall/bypass outputs and EX/MEM next values (bubble by default)
  always_comb begin
    state_d       = state_q;
    hold_req_o    = 1'b0;
    data_bypass_o = '0;
    ex_we         = flush | (hold_code < HOLD_CODE_W'(HOLD_EX));
    res_d         = '0;
    rs2_d         = '0;
    rd_d          = '0;
    wr_d          = 1'b0;
    lc_d          = '0;
    sc_d          = '0;
    case (state_q)
      IDLE: begin
        hold_req_o    = alu_mul_i;
        data_bypass_o = alu_res;
        if (alu_mul_i) begin
          state_d = BUSY;
        end else begin
          res_d = alu_res;
          rs2_d = data_rs2_i;
          rd_d  = addr_rd_i;
          wr_d  = reg_wr_en_i;
          lc_d  = load_code_i;
          sc_d  = store_code_i;
        end
      end
      BUSY: begin
        hold_req_o = 1'b1;
        if (cnt_q == CNT_W'(XLEN-1)) state_d = DONE;
      end
      DONE: begin
        data_bypass_o = acc_q;
        res_d         = acc_q;
        rd_d          = rd_q;
        wr_d          = wr_q;
        if (hold_code < HOLD_CODE_W'(HOLD_EX)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      res_d   = '0;
      rs2_d   = '0;
      rd_d    = '0;
      wr_d    = 1'b0;
      lc_d    = '0;
      sc_d    = '0;
    end
  end

  // Shift-add multiplier datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      rd_q     <= '0;
      wr_q     <= 1'b0;
    end else begin
      if (state_q == IDLE && alu_mul_i) begin
        mcand_q  <= alu_op_num1_i;
        mplier_q <= alu_op_num2_i;
        rd_q     <= addr_rd_i;
        wr_q     <= reg_wr_en_i;
        acc_q    <= '0;
        cnt_q    <= '0;
      end else if (state_q == BUSY) begin
        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CNT_W'(1);
      end
      if (flush) cnt_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_o <= '0;
      data_rs2_o   <= '0;
      addr_rd_o    <= '0;
      reg_wr_en_o  <= 1'b0;
      load_code_o  <= '0;
      store_code_o <= '0;
    end else if (ex_we) begin
      alu_result_o <= res_d;
      data_rs2_o   <= rs2_d;
      addr_rd_o    <= rd_d;
      reg_wr_en_o  <= wr_d;
      load_code_o  <= lc_d;
      store_code_o <= sc_d;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Randomized self-checking bench for ex_stage against an arithmetic reference model.
// Define EX_FLUSH_EN for both files to exercise the flush path.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  hold_code;
  logic [63:0] num1, num2, rs2_in;
  logic [4:0]  rd_in;
  logic        wr_in;
  logic [2:0]  lc_in;
  logic [1:0]  sc_in;
  logic [2:0]  op;
  logic        sub, sh, mul;
  logic        flush;
  logic [63:0] alu_result, rs2_out, bypass;
  logic [4:0]  rd_out;
  logic        wr_out, hold_req;
  logic [2:0]  lc_out;
  logic [1:0]  sc_out;

  logic [63:0] exp_res, exp_rs2;
  logic [4:0]  exp_rd;
  logic        exp_wr;
  logic [2:0]  exp_lc;
  logic [1:0]  exp_sc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst_n(rst_n), .hold_code(hold_code),
    .alu_op_num1_i(num1), .alu_op_num2_i(num2), .data_rs2_i(rs2_in),
    .addr_rd_i(rd_in), .reg_wr_en_i(wr_in), .load_code_i(lc_in), .store_code_i(sc_in),
    .alu_operation_i(op), .alu_add_sub_i(sub), .alu_shift_i(sh), .alu_mul_i(mul),
`ifdef EX_FLUSH_EN
    .flush_i(flush),
`endif
    .alu_result_o(alu_result), .data_rs2_o(rs2_out), .addr_rd_o(rd_out),
    .reg_wr_en_o(wr_out), .load_code_o(lc_out), .store_code_o(sc_out),
    .data_bypass_o(bypass), .hold_req_o(hold_req)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_alu(input logic [2:0] o, input logic s, input logic a_sh,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [63:0] ones = '1;
    logic [63:0] sb   = 64'h8000_0000_0000_0000;
    logic [63:0] r;
    int          n    = int'(b & 64'd63);
    case (o)
      3'd0: r = s ? a + ~b + 64'd1 : a + b;
      3'd1: r = a << n;
      3'd2: r = ((a ^ sb) < (b ^ sb)) ? 64'd1 : 64'd0;
      3'd3: r = (a < b) ? 64'd1 : 64'd0;
      3'd4: r = a ^ b;
      3'd5: begin
        r = a >> n;
        if (a_sh && a[63]) r = r | ~(ones >> n);
      end
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic set_bubble();
    exp_res = '0; exp_rs2 = '0; exp_rd = '0; exp_wr = 1'b0; exp_lc = '0; exp_sc = '0;
  endtask

  task automatic check_exmem(input string tag);
    check({tag, "_res"}, alu_result, exp_res);
    check({tag, "_rs2"}, rs2_out, exp_rs2);
    check({tag, "_rd"},  64'(rd_out), 64'(exp_rd));
    check({tag, "_wr"},  64'(wr_out), 64'(exp_wr));
    check({tag, "_lc"},  64'(lc_out), 64'(exp_lc));
    check({tag, "_sc"},  64'(sc_out), 64'(exp_sc));
  endtask

  function automatic logic exmem_differs();
    return (alu_result !== exp_res) || (rs2_out !== exp_rs2) || (rd_out !== exp_rd) ||
           (wr_out !== exp_wr) || (lc_out !== exp_lc) || (sc_out !== exp_sc);
  endfunction

  // One ALU instruction; entered and left at a falling edge
  task automatic do_alu(input logic [2:0] o, input logic s, input logic a_sh,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] rd, input logic wr, input logic [2:0] h,
                        input string tag);
    logic [63:0] e;
    op = o; sub = s; sh = a_sh; num1 = a; num2 = b; rd_in = rd; wr_in = wr;
    mul = 1'b0; hold_code = h;
    lc_in = 3'($urandom); sc_in = 2'($urandom); rs2_in = rnd64();
    e = ref_alu(o, s, a_sh, a, b);
    #1;
    check({tag, "_bypass"}, bypass, e);
    check({tag, "_holdreq"}, 64'(hold_req), 64'd0);
    @(negedge clk);
    if (h < 3'd3) begin
      exp_res = e; exp_rs2 = rs2_in; exp_rd = rd; exp_wr = wr; exp_lc = lc_in; exp_sc = sc_in;
    end
    check_exmem(tag);
  endtask

  // One MUL with random hold during BUSY and done_hold cycles of hold in DONE
  task automatic do_mul(input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                        input logic wr, input int done_hold, input string tag);
    logic [63:0] prod = a * b;
    logic [2:0]  h;
    int          hi_cnt = 1;
    int          bad = 0;
    num1 = a; num2 = b; rd_in = rd; wr_in = wr; mul = 1'b1;
    op = 3'($urandom); lc_in = 3'($urandom); sc_in = 2'($urandom); rs2_in = rnd64();
    hold_code = 3'($urandom);
    #1;
    check({tag, "_req_start"}, 64'(hold_req), 64'd1);
    for (int i = 0; i < 200; i++) begin
      h = hold_code;
      @(negedge clk);
      if (h < 3'd3) set_bubble();
      if (!hold_req) break;
      hi_cnt++;
      if (exmem_differs() || bypass !== 64'd0) bad++;
      mul = 1'($urandom); hold_code = 3'($urandom);
      num1 = rnd64(); num2 = rnd64(); rd_in = 5'($urandom); wr_in = 1'($urandom);
    end
    check({tag, "_req_cycles"}, 64'(hi_cnt), 64'd65);
    check({tag, "_busy_bad"}, 64'(bad), 64'd0);
    check({tag, "_done_bypass"}, bypass, prod);
    check_exmem({tag, "_done"});
    bad = 0;
    for (int k = 0; k < done_hold; k++) begin
      hold_code = 3'($urandom_range(3, 7)); mul = 1'($urandom);
      @(negedge clk);
      if (exmem_differs() || hold_req !== 1'b0 || bypass !== prod) bad++;
    end
    check({tag, "_done_hold_bad"}, 64'(bad), 64'd0);
    hold_code = 3'($urandom_range(0, 2)); mul = 1'b0;
    @(negedge clk);
    exp_res = prod; exp_rs2 = '0; exp_rd = rd; exp_wr = wr; exp_lc = '0; exp_sc = '0;
    check_exmem({tag, "_wb"});
    check({tag, "_idle_req"}, 64'(hold_req), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; hold_code = '0; num1 = '0; num2 = '0; rs2_in = '0; rd_in = '0; wr_in = 1'b0;
    lc_in = '0; sc_in = '0; op = '0; sub = 1'b0; sh = 1'b0; mul = 1'b0; flush = 1'b0;
    set_bubble();
    #1;
    check_exmem("reset");
    check("reset_holdreq", 64'(hold_req), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    do_alu(3'd0, 1'b0, 1'b0, 64'd5, 64'd7, 5'd3, 1'b1, 3'd0, "add");
    do_alu(3'd0, 1'b1, 1'b0, 64'd3, 64'd5, 5'd4, 1'b1, 3'd1, "sub");
    do_alu(3'd2, 1'b0, 1'b0, '1, 64'd1, 5'd5, 1'b1, 3'd2, "slt");
    do_alu(3'd3, 1'b0, 1'b0, '1, 64'd1, 5'd6, 1'b1, 3'd0, "sltu");
    do_alu(3'd5, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'd4, 5'd7, 1'b1, 3'd0, "sra");
    do_alu(3'd5, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 5'd8, 1'b1, 3'd0, "srl");
    do_alu(3'd1, 1'b0, 1'b0, 64'h1, 64'd68, 5'd9, 1'b1, 3'd0, "sll68");
    check("sub_const", ref_alu(3'd0, 1'b1, 1'b0, 64'd3, 64'd5), 64'hFFFF_FFFF_FFFF_FFFE);
    do_alu(3'd0, 1'b0, 1'b0, 64'd100, 64'd1, 5'd11, 1'b1, 3'd3, "add_held");

    do_mul(64'd6, 64'd7, 5'd10, 1'b1, 0, "mul42");
    do_mul('1, 64'd3, 5'd12, 1'b1, 3, "mulneg");

    for (int i = 0; i < 300; i++) begin
      do_alu(3'($urandom), 1'($urandom), 1'($urandom), rnd64(),
             ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 200)) : rnd64(),
             5'($urandom), 1'($urandom), 3'($urandom_range(0, 4)), "rand_alu");
      if (i % 60 == 0)
        do_mul(rnd64(), rnd64(), 5'($urandom), 1'($urandom), $urandom_range(0, 3), "rand_mul");
    end

    // Asynchronous reset in the middle of a multiply
    num1 = 64'd9; num2 = 64'd9; mul = 1'b1; hold_code = '0;
    for (int i = 0; i < 10; i++) @(negedge clk);
    mul = 1'b0; op = 3'd4; num1 = 64'hF0; num2 = 64'h0F;
    #2 rst_n = 1'b0;
    #1;
    set_bubble();
    check_exmem("midrst");
    check("midrst_holdreq", 64'(hold_req), 64'd0);
    check("midrst_bypass", bypass, 64'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    do_alu(3'd6, 1'b0, 1'b0, 64'h30, 64'h03, 5'd1, 1'b1, 3'd0, "post_rst");

`ifdef EX_FLUSH_EN
    num1 = 64'd5; num2 = 64'd5; rd_in = 5'd2; wr_in = 1'b1; mul = 1'b1; hold_code = '0;
    @(negedge clk);
    mul = 1'b0;
    for (int i = 0; i < 9; i++) @(negedge clk);
    check("flush_busy_req", 64'(hold_req), 64'd1);
    flush = 1'b1; hold_code = 3'd7;
    @(negedge clk);
    flush = 1'b0; hold_code = '0;
    #1;
    set_bubble();
    check_exmem("flush");
    check("flush_req", 64'(hold_req), 64'd0);
    @(negedge clk);
    do_mul(64'd11, 64'd13, 5'd20, 1'b1, 1, "mul_after_flush");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the ECNURVCORE pipeline.
- Consumes the ID/EX register bundle: operands, ALU controls, rd, and load/store codes.
- Computes the ALU result, or an iterative multiply for MUL, and registers it into the EX/MEM pipeline register.
- Returns the forwarding result and a hold request to the decode side; the hold controller turns hold_req_o into hold_code.

Parameters:
- XLEN, 64, datapath width.
- L_CODE_W, 3, load code width.
- S_CODE_W, 2, store code width.
- HOLD_CODE_W, 3, hold_code width.
- HOLD_EX, 3, EX/MEM register is frozen when hold_code >= HOLD_EX.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- hold_code  in  HOLD_CODE_W  pipeline hold level.
- alu_op_num1_i  in  XLEN  operand 1.
- alu_op_num2_i  in  XLEN  operand 2.
- data_rs2_i  in  XLEN  store data.
- addr_rd_i  in  5  destination register.
- reg_wr_en_i  in  1  writeback enable.
- load_code_i  in  L_CODE_W  load code; 0 = none.
- store_code_i  in  S_CODE_W  store code; 0 = none.
- alu_operation_i  in  3  000 add/sub, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl/sra, 110 or, 111 and.
- alu_add_sub_i  in  1  1 = subtract.
- alu_shift_i  in  1  1 = arithmetic right shift.
- alu_mul_i  in  1  1 = MUL; low XLEN bits of num1*num2.
- flush_i  in  1  squash; present only with EX_FLUSH_EN.
- alu_result_o  out  XLEN  EX/MEM result.
- data_rs2_o  out  XLEN  EX/MEM store data.
- addr_rd_o  out  5  EX/MEM destination register.
- reg_wr_en_o  out  1  EX/MEM writeback enable.
- load_code_o  out  L_CODE_W  EX/MEM load code.
- store_code_o  out  S_CODE_W  EX/MEM store code.
- data_bypass_o  out  XLEN  combinational forwarding value.
- hold_req_o  out  1  multi-cycle stall request.

Behaviour:
- Reset: clk and async active-low rst_n as fixed for this block. All registered outputs are 0, state = IDLE, counter = 0. A reset mid-multiply aborts it immediately.
- ALU is combinational.
  - Shift amount = num2[log2(XLEN)-1:0].
  - slt is signed; sltu is unsigned; result is 0 or 1.
  - Add and sub wrap modulo 2^XLEN.
- data_bypass_o:
  - ALU result in IDLE.
  - Product register value in DONE.
  - 0 in BUSY.
- EX/MEM register, updated on an edge only when hold_code < HOLD_EX:
  - IDLE with alu_mul_i = 0: load the ALU result and all pass-through fields.
  - IDLE with alu_mul_i = 1, or BUSY: load a bubble. reg_wr_en_o = 0, load/store codes = 0, other fields = 0.
  - DONE: load the product, the latched rd and the latched wr_en; codes = 0.
  - hold_code >= HOLD_EX: all EX/MEM outputs keep their value.
- Multiply FSM:
  - IDLE, alu_mul_i = 1: on the next edge latch mcand = num1, mplier = num2, rd, wr_en; acc = 0, cnt = 0; go to BUSY. This happens regardless of hold_code.
  - BUSY, every edge: if mplier[0], acc += mcand; then mcand <<= 1, mplier >>= 1, cnt++. When cnt == XLEN-1, perform the last iteration and go to DONE. Iterations continue while held.
  - DONE: go to IDLE on an edge with hold_code < HOLD_EX, writing the product. Otherwise stay in DONE.
- hold_req_o = (IDLE & alu_mul_i) | BUSY.
  - High for exactly XLEN+1 consecutive cycles per MUL when unheld.
  - Low in DONE, so the ID/EX register advances on the same edge that writes the product.
- Timing: an ALU result appears in EX/MEM 1 edge after presentation. A MUL product appears XLEN+2 edges after presentation.
- Inputs are ignored in BUSY and DONE; the hold controller keeps ID/EX frozen during that time.
- Back-to-back MULs: after DONE returns to IDLE, a newly presented MUL starts a fresh sequence.

Optional Feature:
- Macro: EX_FLUSH_EN.
- Defined: the flush_i port exists.
  - flush_i = 1 on an edge writes a bubble into EX/MEM, overriding hold.
  - It forces the FSM to IDLE, clears cnt, and drops hold_req_o in the cycle after the flush.
  - Flush wins over simultaneous MUL start or DONE writeback.
- Undefined: no flush_i port. Bubbles come only from the decode side; the FSM is never aborted except by reset.

Test Plan:
- Reset: assert rst_n = 0 mid-cycle -> all outputs 0 immediately, hold_req_o = 0, FSM IDLE.
- ADD: op 000, sub = 0, num1 = 5, num2 = 7, rd = 3, wr = 1 -> data_bypass_o = 12 in the same cycle; next edge alu_result_o = 12, addr_rd_o = 3, reg_wr_en_o = 1.
- SUB/SLT/SLTU:
  - 3 - 5 -> 0xFFFFFFFFFFFFFFFE.
  - slt(-1, 1) = 1.
  - sltu(-1, 1) = 0.
- Shifts with num1 = 0x8000000000000000, num2 = 4:
  - sra -> 0xF800000000000000.
  - srl -> 0x0800000000000000.
  - num2 = 68 on sll -> shift by 4.
- MUL: num1 = 6, num2 = 7, rd = 10 -> hold_req_o high 65 cycles, EX/MEM bubbles throughout, then alu_result_o = 42, addr_rd_o = 10, reg_wr_en_o = 1. Repeat with -1 * 3 -> 0xFFFFFFFFFFFFFFFD.
- Hold and flush:
  - hold_code = 3 during ADD -> EX/MEM unchanged.
  - hold during DONE -> product delayed until hold_code < 3.
  - With EX_FLUSH_EN, flush_i at BUSY cycle 10 -> IDLE next cycle, bubble written, hold_req_o = 0.
